jtframe_mr_ddrrsp: RTL

JTFRAME_MR_DDRRSP -- requirements
Module: jtframe_mr_ddrrsp

---
 rtl/jtframe_mr_ddrrsp.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/jtframe_mr_ddrrsp.sv
// Behavioural DDR responder: burst writes with byte enables and fixed-latency burst reads on a 64-bit memory.
// Optional JTFRAME_MR_DDRRSP_STALL_EN adds a periodic wait-request every 8th cycle.
module jtframe_mr_ddrrsp #(
    parameter int AW    = 10,
    parameter int RDLAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ddr_burstcnt,
    input  logic [28:0] ddr_addr,
    input  logic        ddr_rd,
    input  logic        ddr_we,
    input  logic [7:0]  ddr_be,
    input  logic [63:0] ddr_din,
    output logic        ddr_busy,
    output logic [63:0] ddr_dout,
    output logic        ddr_dout_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RDWAIT,
        ST_READ
    } state_t;

    localparam logic [3:0]    LAT_INIT = 4'(RDLAT - 1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [3:0]    lat_q, lat_d;
    logic [63:0]   dout_q, dout_d;
    logic          rdy_q, rdy_d;

    logic [63:0]   mem [0:(1<<AW)-1];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [63:0]   mem_wdata;
    logic [7:0]    mem_be;

    logic [7:0]    blen;
    logic          stall;
    logic          unused_addr;

    assign unused_addr = ^ddr_addr[28:AW];
    assign blen        = (ddr_burstcnt == 8'd0) ? 8'd1 : ddr_burstcnt;

`ifdef JTFRAME_MR_DDRRSP_STALL_EN
    logic [2:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= 3'd0;
        else        stall_q <= stall_q + 3'd1;
    end

    assign stall = (stall_q == 3'd7);
`else
    assign stall = 1'b0;
`endif

    assign ddr_busy       = (state_q == ST_RDWAIT) || (state_q == ST_READ) || stall;
    assign ddr_dout       = dout_q;
    assign ddr_dout_ready = rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= 8'd0;
            lat_q   <= 4'd0;
            dout_q  <= 64'd0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            dout_q  <= dout_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        dout_d    = dout_q;
        rdy_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = ddr_din;
        mem_be    = ddr_be;
        case (state_q)
            ST_IDLE: begin
                // a write request takes priority; a simultaneous read is dropped
                if (ddr_we && !ddr_busy) begin
                    mem_we    = 1'b1;
                    mem_waddr = ddr_addr[AW-1:0];
                    addr_d    = ddr_addr[AW-1:0] + ADDR_ONE;
                    cnt_d     = blen - 8'd1;
                    if (blen > 8'd1) state_d = ST_WRITE;
                end else if (ddr_rd && !ddr_busy) begin
                    addr_d  = ddr_addr[AW-1:0];
                    cnt_d   = blen;
                    lat_d   = LAT_INIT;
                    state_d = (RDLAT == 1) ? ST_READ : ST_RDWAIT;
                end
            end
            ST_WRITE: begin
                if (ddr_we && !ddr_busy) begin
                    mem_we = 1'b1;
                    addr_d = addr_q + ADDR_ONE;
                    cnt_d  = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) state_d = ST_IDLE;
                end
            end
            ST_RDWAIT: begin
                lat_d = lat_q - 4'd1;
                if (lat_q <= 4'd1) state_d = ST_READ;
            end
            ST_READ: begin
                rdy_d  = 1'b1;
                dout_d = mem[addr_q];
                addr_d = addr_q + ADDR_ONE;
                cnt_d  = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // memory contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (mem_be[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

endmodule
